// File: rtl/nmi_bus_guard.sv
// nmi_bus_guard: registered slice from the SERV merged memory port to the
// native memory interface (NMI). Each strobe becomes one valid/ready
// transaction and is completed upstream with a one-cycle registered ack.
// Optional watchdog: define NMI_BUS_GUARD_TIMEOUT_EN to abort stalled
// transactions after TIMEOUT valid cycles, returning ERR_DATA and latching
// a sticky error flag plus the faulting address.
module nmi_bus_guard #(
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_stb_i,
  output logic [31:0] wb_rdt_o,
  output logic        wb_ack_o,
  output logic        nmi_valid_o,
  output logic [31:0] nmi_addr_o,
  output logic [31:0] nmi_wdata_o,
  output logic [3:0]  nmi_wstrb_o,
  input  logic [31:0] nmi_rdata_i,
  input  logic        nmi_ready_i,
  input  logic        err_clr_i,
  output logic        err_o,
  output logic [31:0] err_addr_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        valid_q, valid_d;
  logic        ack_q, ack_d;
  logic [31:0] rdt_q, rdt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;

`ifdef NMI_BUS_GUARD_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          err_set;
  logic [31:0]   err_addr_q, err_addr_d;
`endif

  // Next-state logic for the transaction FSM and its captured fields.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    ack_d   = 1'b0;
    rdt_d   = rdt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
`ifdef NMI_BUS_GUARD_TIMEOUT_EN
    cnt_d      = cnt_q;
    err_set    = 1'b0;
    err_addr_d = err_addr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (wb_stb_i) begin
          addr_d  = wb_adr_i;
          wdata_d = wb_dat_i;
          wstrb_d = wb_we_i ? wb_sel_i : 4'h0;
          valid_d = 1'b1;
          state_d = S_REQ;
`ifdef NMI_BUS_GUARD_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      S_REQ: begin
        // Ready takes priority over an expiry in the same cycle.
        if (nmi_ready_i) begin
          rdt_d   = nmi_rdata_i;
          valid_d = 1'b0;
          ack_d   = 1'b1;
          state_d = S_ACK;
        end
`ifdef NMI_BUS_GUARD_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          rdt_d      = ERR_DATA;
          err_set    = 1'b1;
          err_addr_d = addr_q;
          valid_d    = 1'b0;
          ack_d      = 1'b1;
          state_d    = S_ACK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      S_ACK: begin
        // Upstream drops strobe after ack, so it is not sampled here.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase
`ifdef NMI_BUS_GUARD_TIMEOUT_EN
    // Set beats clear when both happen together.
    err_d = err_set | (err_q & ~err_clr_i);
`endif
  end

  // Transaction registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      valid_q <= 1'b0;
      ack_q   <= 1'b0;
      rdt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      ack_q   <= ack_d;
      rdt_q   <= rdt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
    end
  end

`ifdef NMI_BUS_GUARD_TIMEOUT_EN
  // Watchdog counter and sticky error state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q      <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign err_o      = err_q;
  assign err_addr_o = err_addr_q;
`else
  // Watchdog absent: error outputs are constant, clear input is a no-op.
  logic unused_cfg;
  assign unused_cfg = ^{err_clr_i, ERR_DATA, 32'(TIMEOUT)};
  assign err_o      = 1'b0;
  assign err_addr_o = '0;
`endif

  assign wb_rdt_o    = rdt_q;
  assign wb_ack_o    = ack_q;
  assign nmi_valid_o = valid_q;
  assign nmi_addr_o  = addr_q;
  assign nmi_wdata_o = wdata_q;
  assign nmi_wstrb_o = wstrb_q;

endmodule
